cpu7_exu_lsu: RTL and testbench
===============================

Name: cpu7_exu_lsu

Overview:
Single-outstanding load/store unit. It accepts one memory op per dispatch from the EXU control logic over the ecl_lsu_* interface and drives an SRAM-like data bus (req/addr_ok/data_ok). It returns load data, destination register and write-enable on the lsu_ecl_*_m interface. Every accepted op, including stores and faulting ops, ends with exactly one lsu_ecl_rdata_valid_m pulse, which releases the EXU stall.

Parameters:
GRLEN, 32, datapath and address width; only 32 is supported.

Ports:
clk  in  1  clock
resetn  in  1  synchronous reset, active-low
ecl_lsu_valid_e  in  1  op dispatch strobe, one cycle
ecl_lsu_op_e  in  LSOC1K_LSU_CODE_BIT  op code: LD_B/LD_H/LD_W/LD_BU/LD_HU/ST_B/ST_H/ST_W (decoded.vh macros)
ecl_lsu_base_e  in  GRLEN  address base
ecl_lsu_offset_e  in  GRLEN  address offset
ecl_lsu_wdata_e  in  GRLEN  store data, right-aligned
ecl_lsu_rd_e  in  5  load destination register
ecl_lsu_wen_e  in  1  register write request for loads
lsu_ecl_rdata_m  out  GRLEN  extended load result
lsu_ecl_rdata_valid_m  out  1  completion pulse
lsu_ecl_rd_m  out  5  destination register
lsu_ecl_wen_m  out  1  register write enable
lsu_ecl_ale_m  out  1  address-misaligned flag, valid with the completion pulse
data_req  out  1  bus request
data_wr  out  1  1 = write
data_size  out  2  0 = byte, 1 = half, 2 = word
data_addr  out  GRLEN  byte address
data_wdata  out  GRLEN  lane-replicated store data
data_wstrb  out  4  byte strobes
data_addr_ok  in  1  request accepted
data_data_ok  in  1  read data valid or write done
data_rdata  in  GRLEN  read data

Behaviour:
- Reset (resetn = 0 at a clk edge):
  - State goes to IDLE.
  - All outputs are 0: data_req, data_wr, data_size, data_addr, data_wdata, data_wstrb, and all lsu_ecl_* outputs.
- Address: addr = base + offset, modulo 2^32, computed in the E cycle.
  - Misaligned means half with addr[0] = 1, or word with addr[1:0] != 0.
- States: IDLE, REQ, WAIT, DONE.
- IDLE:
  - On ecl_lsu_valid_e, latch op, addr, wdata, rd and wen.
  - Aligned: go to REQ. Misaligned: go to DONE with ale = 1; no bus access occurs.
- REQ:
  - data_req = 1 with stable data_wr, data_size, data_addr, data_wdata, data_wstrb until data_addr_ok.
  - addr_ok without data_ok: go to WAIT and drop data_req next cycle.
  - addr_ok and data_ok in the same cycle: go to DONE and capture rdata.
- WAIT: data_req = 0. On data_data_ok, capture data_rdata and go to DONE.
- DONE (one cycle):
  - lsu_ecl_rdata_valid_m = 1 and lsu_ecl_rd_m = latched rd.
  - lsu_ecl_wen_m = latched wen only for a load with ale = 0; otherwise 0.
  - lsu_ecl_ale_m = ale. Return to IDLE.
  - A new ecl_lsu_valid_e in the DONE cycle is accepted, as in IDLE.
- Outside DONE, all lsu_ecl_* outputs are 0.
- Minimum latency: valid_e at cycle T, data_req at T+1 (addr_ok and data_ok the same cycle), rdata_valid_m at T+2.
  - Misaligned op: rdata_valid_m at T+1.
- Store formatting:
  - Byte: wdata[7:0] replicated to all four lanes; wstrb = 1 << addr[1:0].
  - Half: wdata[15:0] replicated to both halves; wstrb = 4'b0011 << addr[1:0].
  - Word: wdata as is; wstrb = 4'b1111.
  - For loads, wstrb = 0 and data_wdata = 0.
- Load formatting:
  - Shift rdata right by addr[1:0]*8.
  - LD_B/LD_H sign-extend from bit 7/15; LD_BU/LD_HU zero-extend; LD_W passes through.
  - For stores, lsu_ecl_rdata_m = 0.
- ecl_lsu_valid_e in REQ or WAIT is ignored: no second bus request and no extra completion.
- data_data_ok in IDLE or REQ without addr_ok is ignored.
- Reset mid-op (REQ or WAIT):
  - Go to IDLE and drop data_req the same cycle as reset.
  - No completion pulse is produced for the aborted op.
  - A data_ok arriving after reset is ignored.

Test Plan:
1. Reset: resetn = 0 while data_req = 1 in REQ -> next cycle data_req = 0, rdata_valid_m = 0; a later data_ok produces no pulse.
2. LD_B: base 0x1000, offset 3, bus returns 0x80FF_FF00 with addr_ok and data_ok same cycle -> data_size = 0, addr 0x1003, rdata_m 0xFFFF_FF80, wen_m = 1, rd_m echoed, pulse at T+2.
3. LD_HU: addr 0x2002, addr_ok at T+3, data_ok at T+6, rdata 0xBEEF_1234 -> rdata_m 0x0000_BEEF; data_req held T+1..T+3; pulse at T+7.
4. ST_B and ST_H:
   - ST_B: addr 0x11, wdata 0x1234_56AB, ecl_lsu_wen_e = 1 -> data_wr = 1, wdata 0xABAB_ABAB, wstrb 0010; on completion rdata_m = 0 and wen_m = 0.
   - ST_H: addr 0x12, wdata 0x1234_56AB -> wdata 0x56AB_56AB, wstrb 1100.
5. LD_W at 0x1002 -> no data_req; at T+1 rdata_valid_m = 1, ale_m = 1, wen_m = 0.
6. Back-to-back ops:
   - valid_e in WAIT -> ignored.
   - valid_e in the DONE cycle -> accepted, second data_req the next cycle; exactly two completion pulses in total.

Source files
------------

// File: rtl/cpu7_exu_lsu_if.sv
// Op encodings for the load/store unit and the SRAM-like data bus it masters.
// The package sits here so the unit and its users share one definition.
package cpu7_exu_lsu_pkg;
  localparam int LSOC1K_LSU_CODE_BIT = 4;
  typedef logic [LSOC1K_LSU_CODE_BIT-1:0] lsu_op_t;
  localparam lsu_op_t LSU_LD_B  = 4'd0;
  localparam lsu_op_t LSU_LD_H  = 4'd1;
  localparam lsu_op_t LSU_LD_W  = 4'd2;
  localparam lsu_op_t LSU_LD_BU = 4'd3;
  localparam lsu_op_t LSU_LD_HU = 4'd4;
  localparam lsu_op_t LSU_ST_B  = 4'd5;
  localparam lsu_op_t LSU_ST_H  = 4'd6;
  localparam lsu_op_t LSU_ST_W  = 4'd7;
endpackage

interface cpu7_exu_lsu_if #(parameter int GRLEN = 32);
  logic             data_req;
  logic             data_wr;
  logic [1:0]       data_size;
  logic [GRLEN-1:0] data_addr;
  logic [GRLEN-1:0] data_wdata;
  logic [3:0]       data_wstrb;
  logic             data_addr_ok;
  logic             data_data_ok;
  logic [GRLEN-1:0] data_rdata;

  modport master (
    output data_req, data_wr, data_size, data_addr, data_wdata, data_wstrb,
    input  data_addr_ok, data_data_ok, data_rdata
  );

  modport slave (
    input  data_req, data_wr, data_size, data_addr, data_wdata, data_wstrb,
    output data_addr_ok, data_data_ok, data_rdata
  );
endinterface

// File: rtl/cpu7_exu_lsu.sv
// Single-outstanding load/store unit: one dispatched op, one bus transaction,
// exactly one completion pulse (misaligned ops complete without touching the bus).
//
// state | meaning
// IDLE  | no op in flight, dispatch accepted
// REQ   | data_req asserted, waiting for addr_ok
// WAIT  | request accepted, waiting for data_ok
// DONE  | completion pulse on lsu_ecl_*, dispatch accepted
module cpu7_exu_lsu
  import cpu7_exu_lsu_pkg::*;
#(
  parameter int GRLEN = 32
) (
  input  logic                           clk,
  input  logic                           resetn,
  input  logic                           ecl_lsu_valid_e,
  input  logic [LSOC1K_LSU_CODE_BIT-1:0] ecl_lsu_op_e,
  input  logic [GRLEN-1:0]               ecl_lsu_base_e,
  input  logic [GRLEN-1:0]               ecl_lsu_offset_e,
  input  logic [GRLEN-1:0]               ecl_lsu_wdata_e,
  input  logic [4:0]                     ecl_lsu_rd_e,
  input  logic                           ecl_lsu_wen_e,
  output logic [GRLEN-1:0]               lsu_ecl_rdata_m,
  output logic                           lsu_ecl_rdata_valid_m,
  output logic [4:0]                     lsu_ecl_rd_m,
  output logic                           lsu_ecl_wen_m,
  output logic                           lsu_ecl_ale_m,
  cpu7_exu_lsu_if.master                 bus
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  state_t     state;
  lsu_op_t    op_q;
  logic [1:0] addr_lo_q;
  logic [4:0] rd_q;
  logic       wen_q;
  logic       store_q;

  logic [GRLEN-1:0] addr_e, wdata_fmt, shifted, load_ext;
  logic [1:0]       size_e;
  logic [3:0]       wstrb_fmt;
  logic             store_e, mis_e;

  always_comb begin
    addr_e  = ecl_lsu_base_e + ecl_lsu_offset_e;
    store_e = 1'b0;
    size_e  = 2'd2;
    case (ecl_lsu_op_e)
      LSU_LD_B, LSU_LD_BU: size_e = 2'd0;
      LSU_LD_H, LSU_LD_HU: size_e = 2'd1;
      LSU_ST_B: begin size_e = 2'd0; store_e = 1'b1; end
      LSU_ST_H: begin size_e = 2'd1; store_e = 1'b1; end
      LSU_ST_W: store_e = 1'b1;
      default: ;
    endcase
    mis_e = (size_e == 2'd1 && addr_e[0]) || (size_e == 2'd2 && addr_e[1:0] != 2'b00);
    wdata_fmt = '0;
    wstrb_fmt = '0;
    if (store_e) begin
      case (size_e)
        2'd0: begin
          wdata_fmt = {4{ecl_lsu_wdata_e[7:0]}};
          wstrb_fmt = 4'b0001 << addr_e[1:0];
        end
        2'd1: begin
          wdata_fmt = {2{ecl_lsu_wdata_e[15:0]}};
          wstrb_fmt = 4'b0011 << addr_e[1:0];
        end
        default: begin
          wdata_fmt = ecl_lsu_wdata_e;
          wstrb_fmt = 4'b1111;
        end
      endcase
    end
  end

  // Load result is formed from the live bus data in the cycle it is captured.
  always_comb begin
    shifted = bus.data_rdata >> {addr_lo_q, 3'b000};
    case (op_q)
      LSU_LD_B:  load_ext = {{(GRLEN-8){shifted[7]}}, shifted[7:0]};
      LSU_LD_BU: load_ext = {{(GRLEN-8){1'b0}}, shifted[7:0]};
      LSU_LD_H:  load_ext = {{(GRLEN-16){shifted[15]}}, shifted[15:0]};
      LSU_LD_HU: load_ext = {{(GRLEN-16){1'b0}}, shifted[15:0]};
      LSU_LD_W:  load_ext = shifted;
      default:   load_ext = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state                 <= IDLE;
      op_q                  <= LSU_LD_B;
      addr_lo_q             <= '0;
      rd_q                  <= '0;
      wen_q                 <= 1'b0;
      store_q               <= 1'b0;
      bus.data_req          <= 1'b0;
      bus.data_wr           <= 1'b0;
      bus.data_size         <= '0;
      bus.data_addr         <= '0;
      bus.data_wdata        <= '0;
      bus.data_wstrb        <= '0;
      lsu_ecl_rdata_m       <= '0;
      lsu_ecl_rdata_valid_m <= 1'b0;
      lsu_ecl_rd_m          <= '0;
      lsu_ecl_wen_m         <= 1'b0;
      lsu_ecl_ale_m         <= 1'b0;
    end else begin
      lsu_ecl_rdata_m       <= '0;
      lsu_ecl_rdata_valid_m <= 1'b0;
      lsu_ecl_rd_m          <= '0;
      lsu_ecl_wen_m         <= 1'b0;
      lsu_ecl_ale_m         <= 1'b0;
      case (state)
        IDLE, DONE: begin
          state <= IDLE;
          if (ecl_lsu_valid_e) begin
            op_q      <= ecl_lsu_op_e;
            addr_lo_q <= addr_e[1:0];
            rd_q      <= ecl_lsu_rd_e;
            wen_q     <= ecl_lsu_wen_e;
            store_q   <= store_e;
            if (mis_e) begin
              state                 <= DONE;
              lsu_ecl_rdata_valid_m <= 1'b1;
              lsu_ecl_rd_m          <= ecl_lsu_rd_e;
              lsu_ecl_ale_m         <= 1'b1;
            end else begin
              state          <= REQ;
              bus.data_req   <= 1'b1;
              bus.data_wr    <= store_e;
              bus.data_size  <= size_e;
              bus.data_addr  <= addr_e;
              bus.data_wdata <= wdata_fmt;
              bus.data_wstrb <= wstrb_fmt;
            end
          end
        end
        REQ: begin
          if (bus.data_addr_ok) begin
            bus.data_req <= 1'b0;
            if (bus.data_data_ok) begin
              state                 <= DONE;
              lsu_ecl_rdata_valid_m <= 1'b1;
              lsu_ecl_rd_m          <= rd_q;
              lsu_ecl_wen_m         <= wen_q & ~store_q;
              lsu_ecl_rdata_m       <= load_ext;
            end else begin
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          if (bus.data_data_ok) begin
            state                 <= DONE;
            lsu_ecl_rdata_valid_m <= 1'b1;
            lsu_ecl_rd_m          <= rd_q;
            lsu_ecl_wen_m         <= wen_q & ~store_q;
            lsu_ecl_rdata_m       <= load_ext;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu7_exu_lsu.sv
// Scoreboard bench for cpu7_exu_lsu: stimulus pushes expected completions,
// a negedge monitor pops and compares each lsu_ecl_rdata_valid_m pulse.
module tb_cpu7_exu_lsu;
  import cpu7_exu_lsu_pkg::*;

  logic        clk = 1'b0;
  logic        resetn;
  logic        valid_e;
  lsu_op_t     op_e;
  logic [31:0] base_e, offset_e, wdata_e;
  logic [4:0]  rd_e;
  logic        wen_e;
  logic [31:0] rdata_m;
  logic        rdata_valid_m;
  logic [4:0]  rd_m;
  logic        wen_m, ale_m;

  cpu7_exu_lsu_if #(.GRLEN(32)) bus ();

  cpu7_exu_lsu #(.GRLEN(32)) dut (
    .clk                   (clk),
    .resetn                (resetn),
    .ecl_lsu_valid_e       (valid_e),
    .ecl_lsu_op_e          (op_e),
    .ecl_lsu_base_e        (base_e),
    .ecl_lsu_offset_e      (offset_e),
    .ecl_lsu_wdata_e       (wdata_e),
    .ecl_lsu_rd_e          (rd_e),
    .ecl_lsu_wen_e         (wen_e),
    .lsu_ecl_rdata_m       (rdata_m),
    .lsu_ecl_rdata_valid_m (rdata_valid_m),
    .lsu_ecl_rd_m          (rd_m),
    .lsu_ecl_wen_m         (wen_m),
    .lsu_ecl_ale_m         (ale_m),
    .bus                   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rdata;
    logic [4:0]  rd;
    logic        wen;
    logic        ale;
    int          cyc;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   req_count = 0;
  logic req_prev = 1'b0;
  logic mon_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (rdata_valid_m === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_pulse: got pulse at cycle %0d expected none", cyc);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("cmp_rdata", 64'(rdata_m), 64'(e.rdata));
          chk("cmp_rd",    64'(rd_m),    64'(e.rd));
          chk("cmp_wen",   64'(wen_m),   64'(e.wen));
          chk("cmp_ale",   64'(ale_m),   64'(e.ale));
          chk("cmp_cycle", 64'(cyc),     64'(e.cyc));
        end
      end else begin
        chk("idle_outs", 64'({rdata_m, rd_m, wen_m, ale_m}), 64'd0);
      end
      if (bus.data_req === 1'b1 && !req_prev) req_count++;
      req_prev = bus.data_req;
    end
  end

  task automatic push_exp(input logic [31:0] rdata, input logic [4:0] rd,
                          input logic wen, input logic ale, input int lat);
    exp_t e;
    e.rdata = rdata; e.rd = rd; e.wen = wen; e.ale = ale; e.cyc = cyc + lat;
    exp_q.push_back(e);
  endtask

  task automatic drive_valid(input lsu_op_t op, input logic [31:0] base, input logic [31:0] off,
                             input logic [31:0] wd, input logic [4:0] rd, input logic wen);
    valid_e = 1'b1; op_e = op; base_e = base; offset_e = off; wdata_e = wd; rd_e = rd; wen_e = wen;
    @(posedge clk); #1;
    valid_e = 1'b0; op_e = '0; base_e = '0; offset_e = '0; wdata_e = '0; rd_e = '0; wen_e = 1'b0;
  endtask

  task automatic check_bus(input logic wr, input logic [1:0] size, input logic [31:0] addr,
                           input logic [31:0] wd, input logic [3:0] strb);
    chk("bus_req",   64'(bus.data_req),   64'd1);
    chk("bus_wr",    64'(bus.data_wr),    64'(wr));
    chk("bus_size",  64'(bus.data_size),  64'(size));
    chk("bus_addr",  64'(bus.data_addr),  64'(addr));
    chk("bus_wdata", 64'(bus.data_wdata), 64'(wd));
    chk("bus_wstrb", 64'(bus.data_wstrb), 64'(strb));
  endtask

  // Called in the first request cycle; aok = cycles before addr_ok, dok = cycles from addr_ok to data_ok.
  task automatic respond(input int aok, input int dok, input logic [31:0] rd_bus,
                         input logic wr, input logic [1:0] size, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [3:0] strb);
    for (int i = 0; i < aok; i++) begin
      check_bus(wr, size, addr, wd, strb);
      @(posedge clk); #1;
    end
    check_bus(wr, size, addr, wd, strb);
    bus.data_addr_ok = 1'b1;
    if (dok == 0) begin bus.data_data_ok = 1'b1; bus.data_rdata = rd_bus; end
    @(posedge clk); #1;
    bus.data_addr_ok = 1'b0; bus.data_data_ok = 1'b0; bus.data_rdata = 32'h0;
    chk("req_drop", 64'(bus.data_req), 64'd0);
    if (dok > 0) begin
      for (int i = 1; i < dok; i++) begin @(posedge clk); #1; end
      bus.data_data_ok = 1'b1; bus.data_rdata = rd_bus;
      @(posedge clk); #1;
      bus.data_data_ok = 1'b0; bus.data_rdata = 32'h0;
    end
    @(posedge clk); #1;
  endtask

  task automatic run_op(input lsu_op_t op, input logic [31:0] base, input logic [31:0] off,
                        input logic [31:0] wd, input logic [4:0] rd, input logic wen,
                        input int aok, input int dok, input logic [31:0] rd_bus,
                        input logic xwr, input logic [1:0] xsize, input logic [31:0] xaddr,
                        input logic [31:0] xwd, input logic [3:0] xstrb,
                        input logic [31:0] xrdata, input logic xwen);
    push_exp(xrdata, rd, xwen, 1'b0, 2 + aok + dok);
    drive_valid(op, base, off, wd, rd, wen);
    respond(aok, dok, rd_bus, xwr, xsize, xaddr, xwd, xstrb);
  endtask

  task automatic run_mis(input lsu_op_t op, input logic [31:0] base, input logic [31:0] off,
                         input logic [4:0] rd);
    push_exp(32'h0, rd, 1'b0, 1'b1, 1);
    drive_valid(op, base, off, 32'hFFFF_FFFF, rd, 1'b1);
    chk("mis_noreq", 64'(bus.data_req), 64'd0);
    @(posedge clk); #1;
    chk("mis_noreq2", 64'(bus.data_req), 64'd0);
  endtask

  initial begin
    int reqs_before;
    resetn = 1'b0;
    valid_e = 1'b0; op_e = '0; base_e = '0; offset_e = '0; wdata_e = '0; rd_e = '0; wen_e = 1'b0;
    bus.data_addr_ok = 1'b0; bus.data_data_ok = 1'b0; bus.data_rdata = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_bus", 64'({bus.data_req, bus.data_wr, bus.data_size, bus.data_wstrb}), 64'd0);
    chk("rst_addr", 64'(bus.data_addr), 64'd0);
    chk("rst_wdata", 64'(bus.data_wdata), 64'd0);
    chk("rst_lsu", 64'({rdata_m, rdata_valid_m, rd_m, wen_m, ale_m}), 64'd0);
    resetn = 1'b1;
    mon_en = 1'b1;
    @(posedge clk); #1;

    // Reset while in REQ aborts the op; a late data_ok is ignored.
    drive_valid(LSU_LD_W, 32'h100, 32'h0, 32'h0, 5'd9, 1'b1);
    chk("t1_req", 64'(bus.data_req), 64'd1);
    resetn = 1'b0;
    @(posedge clk); #1;
    chk("t1_req_drop", 64'(bus.data_req), 64'd0);
    chk("t1_no_pulse", 64'(rdata_valid_m), 64'd0);
    resetn = 1'b1;
    bus.data_data_ok = 1'b1; bus.data_rdata = 32'hDEAD_0001;
    @(posedge clk); #1;
    bus.data_data_ok = 1'b0; bus.data_rdata = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    chk("t1_idle_req", 64'(bus.data_req), 64'd0);

    // Loads
    run_op(LSU_LD_B, 32'h1000, 32'h3, 32'h0, 5'd5, 1'b1, 0, 0, 32'h80FF_FF00,
           1'b0, 2'd0, 32'h1003, 32'h0, 4'b0000, 32'hFFFF_FF80, 1'b1);
    run_op(LSU_LD_HU, 32'h2000, 32'h2, 32'h0, 5'd6, 1'b1, 2, 3, 32'hBEEF_1234,
           1'b0, 2'd1, 32'h2002, 32'h0, 4'b0000, 32'h0000_BEEF, 1'b1);
    run_op(LSU_LD_H, 32'h3000, 32'h2, 32'h0, 5'd10, 1'b1, 1, 1, 32'h8001_0000,
           1'b0, 2'd1, 32'h3002, 32'h0, 4'b0000, 32'hFFFF_8001, 1'b1);
    run_op(LSU_LD_BU, 32'h5000, 32'h1, 32'h0, 5'd11, 1'b1, 0, 0, 32'h0000_9A00,
           1'b0, 2'd0, 32'h5001, 32'h0, 4'b0000, 32'h0000_009A, 1'b1);
    run_op(LSU_LD_W, 32'hFFFF_FFFC, 32'h8, 32'h0, 5'd12, 1'b0, 0, 2, 32'hDEAD_BEEF,
           1'b0, 2'd2, 32'h0000_0004, 32'h0, 4'b0000, 32'hDEAD_BEEF, 1'b0);

    // Stores
    run_op(LSU_ST_B, 32'h10, 32'h1, 32'h1234_56AB, 5'd7, 1'b1, 0, 1, 32'hFFFF_FFFF,
           1'b1, 2'd0, 32'h11, 32'hABAB_ABAB, 4'b0010, 32'h0, 1'b0);
    run_op(LSU_ST_H, 32'h10, 32'h2, 32'h1234_56AB, 5'd8, 1'b1, 1, 0, 32'hFFFF_FFFF,
           1'b1, 2'd1, 32'h12, 32'h56AB_56AB, 4'b1100, 32'h0, 1'b0);
    run_op(LSU_ST_W, 32'h20, 32'h0, 32'h1122_3344, 5'd3, 1'b0, 0, 0, 32'h0,
           1'b1, 2'd2, 32'h20, 32'h1122_3344, 4'b1111, 32'h0, 1'b0);

    // Misaligned ops complete next cycle with ale and no bus access
    run_mis(LSU_LD_W, 32'h1000, 32'h2, 5'd13);
    run_mis(LSU_LD_H, 32'h3000, 32'h1, 5'd14);
    run_mis(LSU_ST_W, 32'h40, 32'h1, 5'd15);

    // Back-to-back: dispatch in WAIT is ignored, dispatch in DONE is accepted
    reqs_before = req_count;
    push_exp(32'h1234_5678, 5'd20, 1'b1, 1'b0, 4);
    drive_valid(LSU_LD_W, 32'h40, 32'h0, 32'h0, 5'd20, 1'b1);
    check_bus(1'b0, 2'd2, 32'h40, 32'h0, 4'b0000);
    bus.data_addr_ok = 1'b1;
    @(posedge clk); #1;
    bus.data_addr_ok = 1'b0;
    chk("b2b_wait_req", 64'(bus.data_req), 64'd0);
    drive_valid(LSU_ST_W, 32'h80, 32'h0, 32'hCAFE_F00D, 5'd21, 1'b0);
    chk("b2b_ignored", 64'(bus.data_req), 64'd0);
    bus.data_data_ok = 1'b1; bus.data_rdata = 32'h1234_5678;
    @(posedge clk); #1;
    bus.data_data_ok = 1'b0; bus.data_rdata = 32'h0;
    chk("b2b_done", 64'(rdata_valid_m), 64'd1);
    push_exp(32'h0000_0056, 5'd22, 1'b1, 1'b0, 2);
    drive_valid(LSU_LD_BU, 32'h40, 32'h1, 32'h0, 5'd22, 1'b1);
    respond(0, 0, 32'h1234_5678, 1'b0, 2'd0, 32'h41, 32'h0, 4'b0000);
    repeat (3) @(posedge clk);
    #1;
    chk("b2b_req_count", 64'(req_count - reqs_before), 64'd2);
    chk("queue_empty", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
